// File: rtl/wrr_arbiter_pkg.sv
// arbiter_pkg: shared state type, index-width and weight-slice helpers for wrr_arbiter
package arbiter_pkg;
  typedef enum logic {IDLE, LOCK} state_e;
  localparam int MAX_BUS = 256;
  localparam int MAX_WW = 32;
  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction
  function automatic logic [MAX_WW-1:0] weight_slice(input logic [MAX_BUS-1:0] bus, input int i, input int ww);
    return MAX_WW'((bus >> (i * ww)) & ((MAX_BUS'(1) << ww) - MAX_BUS'(1)));
  endfunction
endpackage

// File: rtl/wrr_arbiter_if.sv
// wrr_arbiter_if: requester-side controls (init/en/req/weight/beat/last) in, grant status out
interface wrr_arbiter_if
  import arbiter_pkg::*;
#(
  parameter int NUM_REQUEST = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int REQ_INDEX_WIDTH = idx_width(NUM_REQUEST)
);
  logic init_in;
  logic en_in;
  logic [NUM_REQUEST-1:0] req_in;
  logic [NUM_REQUEST*WEIGHT_WIDTH-1:0] weight_in;
  logic beat_in;
  logic last_in;
  logic granted_out;
  logic [NUM_REQUEST-1:0] grant_out;
  logic [REQ_INDEX_WIDTH-1:0] grant_idx_out;
  logic [WEIGHT_WIDTH-1:0] quota_out;
  modport master (
    output init_in, en_in, req_in, weight_in, beat_in, last_in,
    input granted_out, grant_out, grant_idx_out, quota_out
  );
  modport slave (
    input init_in, en_in, req_in, weight_in, beat_in, last_in,
    output granted_out, grant_out, grant_idx_out, quota_out
  );
endinterface

// File: rtl/wrr_arbiter_prior_encoder.sv
// prior_encoder: position of the lowest set bit of in_i, valid_o when any bit is set
module prior_encoder #(
  parameter int W = 4,
  parameter int OW = 3
) (
  input  logic [W-1:0]  in_i,
  output logic [OW-1:0] pos_o,
  output logic          valid_o
);
  always_comb begin
    pos_o = '0;
    valid_o = 1'b0;
    for (int k = W - 1; k >= 0; k--) begin
      if (in_i[k]) begin
        pos_o = OW'(k);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wrr_arbiter_rr_pick.sv
// rr_pick: 1-based index of first request at or above rr_pnt_i with wrap, 0 if none
module rr_pick #(
  parameter int N = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW:0]   rr_pnt_i,
  output logic [IW-1:0] idx_o
);
  logic [2*N-1:0] doubled;
  logic [N-1:0] window;
  logic [IW-1:0] pos;
  logic valid;
  logic [IW:0] s;
  assign doubled = {req_i, req_i};
  assign window = N'(doubled >> (rr_pnt_i - (IW+1)'(1)));
  prior_encoder #(.W(N), .OW(IW)) u_enc (.in_i(window), .pos_o(pos), .valid_o(valid));
  assign s = rr_pnt_i - (IW+1)'(1) + (IW+1)'(pos);
  assign idx_o = !valid ? '0 : IW'(s >= (IW+1)'(N) ? s - (IW+1)'(N) + (IW+1)'(1) : s + (IW+1)'(1));
endmodule

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter, holds a grant for up to weight beats
module wrr_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_REQUEST = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int REQ_INDEX_WIDTH = idx_width(NUM_REQUEST)
) (
  input logic clk,
  input logic rst,
  wrr_arbiter_if.slave bus
);
  localparam int PW = REQ_INDEX_WIDTH + 1;
  state_e state_q, state_d;
  logic [PW-1:0] rr_pnt_q, rr_pnt_d, nxt;
  logic [REQ_INDEX_WIDTH-1:0] idx_q, idx_d, pick;
  logic [WEIGHT_WIDTH-1:0] quota_q, quota_d, w;
  logic [NUM_REQUEST-1:0] grant_oh;
  logic rel;
  rr_pick #(.N(NUM_REQUEST), .IW(REQ_INDEX_WIDTH)) u_pick (.req_i(bus.req_in), .rr_pnt_i(rr_pnt_q), .idx_o(pick));
  assign w = WEIGHT_WIDTH'(weight_slice(MAX_BUS'(bus.weight_in), int'(pick) - 1, WEIGHT_WIDTH));
  always_comb begin
    grant_oh = '0;
    for (int k = 0; k < NUM_REQUEST; k++) grant_oh[k] = idx_q == REQ_INDEX_WIDTH'(k + 1);
  end
  assign rel = !(|(bus.req_in & grant_oh)) || (bus.beat_in && (quota_q == WEIGHT_WIDTH'(1) || bus.last_in));
  assign nxt = PW'(idx_q) + PW'(1);
  always_comb begin
    state_d = state_q;
    rr_pnt_d = rr_pnt_q;
    idx_d = idx_q;
    quota_d = quota_q;
    if (bus.init_in) begin
      state_d = IDLE;
      rr_pnt_d = PW'(1);
      idx_d = '0;
      quota_d = '0;
    end else if (state_q == IDLE) begin
      if (bus.en_in && pick != '0) begin
        state_d = LOCK;
        idx_d = pick;
        quota_d = w == '0 ? WEIGHT_WIDTH'(1) : w;
      end
    end else if (rel) begin
      state_d = IDLE;
      idx_d = '0;
      quota_d = '0;
      rr_pnt_d = nxt > PW'(NUM_REQUEST) ? PW'(1) : nxt;
    end else if (bus.beat_in) begin
      quota_d = quota_q - WEIGHT_WIDTH'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_pnt_q <= PW'(1);
      idx_q <= '0;
      quota_q <= '0;
    end else begin
      state_q <= state_d;
      rr_pnt_q <= rr_pnt_d;
      idx_q <= idx_d;
      quota_q <= quota_d;
    end
  end
  assign bus.granted_out = state_q == LOCK;
  assign bus.grant_out = grant_oh;
  assign bus.grant_idx_out = idx_q;
  assign bus.quota_out = quota_q;
endmodule
